// File: rtl/fp_pkg.sv
// Shared FP32 constants, rounding-mode and operand-class enums for the
// floating-point ALU's iterative units (divider, square root).
package fp_pkg;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_BIAS  = 127;

    localparam logic [FP_EXP_W-1:0] FP_EXP_MAX   = 8'hFF;
    localparam logic [31:0]         FP_NAN_CANON = 32'h7FC00000;
    localparam logic [30:0]         FP_INF_MAG   = 31'h7F800000;
    localparam logic [30:0]         FP_MAXF_MAG  = 31'h7F7FFFFF;

    typedef enum logic [2:0] {
        FP_RM_RNE = 3'b000,
        FP_RM_RTZ = 3'b001,
        FP_RM_RDN = 3'b010,
        FP_RM_RUP = 3'b011,
        FP_RM_RMM = 3'b100
    } fp_rm_e;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;
endpackage

// File: rtl/fp_classify.sv
// Splits an FP32 operand into fields, flushes subnormals to signed zero and
// decodes its class. Purely combinational.
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0]         x,
    output logic                sign,
    output logic [FP_EXP_W-1:0] expo,
    output logic [FP_MAN_W:0]   man,
    output fp_class_e           cls
);
    logic [FP_EXP_W-1:0] e;
    logic [FP_MAN_W-1:0] f;

    assign e = x[30:23];
    assign f = x[22:0];

    always_comb begin
        sign = x[31];
        expo = e;
        man  = {1'b1, f};
        cls  = FP_NORM;
        if (e == '0) begin
            expo = '0;
            man  = '0;
            cls  = FP_ZERO;
        end else if (e == FP_EXP_MAX) begin
            cls = (f == '0) ? FP_INF : FP_NAN;
        end
    end
endmodule

// File: rtl/fp_div_seq.sv
// Iterative FP32 divider: one restoring quotient bit per cycle, answering the
// ALU's valid/halt stall handshake.
module fp_div_seq
    import fp_pkg::*;
#(
    parameter int          ITER      = 27,
    parameter logic [31:0] NAN_CANON = FP_NAN_CANON
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [31:0] reg_a,
    input  logic [31:0] reg_b,
    input  logic [2:0]  rm,
    output logic [31:0] reg_out,
    output logic [3:0]  halt
);
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_ROUND, S_DONE} state_e;

    state_e state, state_nx;

    logic                sa, sb, s_new;
    logic [FP_EXP_W-1:0] ea, eb;
    logic [FP_MAN_W:0]   ma, mb;
    fp_class_e           ca, cb;

    fp_classify u_cls_a (.x(reg_a), .sign(sa), .expo(ea), .man(ma), .cls(ca));
    fp_classify u_cls_b (.x(reg_b), .sign(sb), .expo(eb), .man(mb), .cls(cb));

    assign s_new = sa ^ sb;

    logic               sign_q;
    logic signed [9:0]  exp_q;
    logic [24:0]        rem_q;
    logic [23:0]        div_q;
    logic [26:0]        q_q;
    logic [4:0]         cnt_q;

    logic        is_special;
    logic [31:0] special_res;

    always_comb begin
        is_special  = 1'b1;
        special_res = NAN_CANON;
        if (ca == FP_NAN || cb == FP_NAN || (ca == FP_ZERO && cb == FP_ZERO) ||
            (ca == FP_INF && cb == FP_INF))
            special_res = NAN_CANON;
        else if (ca == FP_INF || cb == FP_ZERO)
            special_res = {s_new, FP_INF_MAG};
        else if (ca == FP_ZERO || cb == FP_INF)
            special_res = {s_new, 31'd0};
        else
            is_special = 1'b0;
    end

    // Remainder stays below the divisor after a step, so the shift never overflows 25 bits.
    logic        rem_ge;
    logic [24:0] rem_sub;
    logic        last_iter;

    assign rem_ge    = rem_q >= {1'b0, div_q};
    assign rem_sub   = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;
    assign last_iter = (cnt_q == 5'(ITER - 1));

    logic [23:0]       mant;
    logic              guard, sticky, rnd_up, carry;
    logic [24:0]       mant_r;
    logic [22:0]       frac;
    logic signed [9:0] exp_n, exp_f;
    logic [31:0]       round_res;

    always_comb begin
        mant      = q_q[26:3];
        guard     = q_q[2];
        sticky    = (|q_q[1:0]) | (rem_q != '0);
        exp_n     = exp_q;
        rnd_up    = 1'b0;
        round_res = {sign_q, 31'd0};
        if (!q_q[26]) begin
            mant   = q_q[25:2];
            guard  = q_q[1];
            sticky = q_q[0] | (rem_q != '0);
            exp_n  = exp_q - 10'sd1;
        end
        case (fp_rm_e'(rm))
            FP_RM_RTZ: rnd_up = 1'b0;
            FP_RM_RDN: rnd_up = sign_q & (guard | sticky);
            FP_RM_RUP: rnd_up = ~sign_q & (guard | sticky);
            FP_RM_RMM: rnd_up = guard;
            default:   rnd_up = guard & (sticky | mant[0]);
        endcase
        mant_r = {1'b0, mant} + 25'(rnd_up);
        carry  = mant_r[24];
        frac   = carry ? mant_r[23:1] : mant_r[22:0];
        exp_f  = exp_n + (carry ? 10'sd1 : 10'sd0);
        if (exp_f <= 10'sd0) begin
            round_res = {sign_q, 31'd0};
        end else if (exp_f >= 10'sd255) begin
            case (fp_rm_e'(rm))
                FP_RM_RTZ: round_res = {sign_q, FP_MAXF_MAG};
                FP_RM_RUP: round_res = sign_q ? {1'b1, FP_MAXF_MAG} : {1'b0, FP_INF_MAG};
                FP_RM_RDN: round_res = sign_q ? {1'b1, FP_INF_MAG} : {1'b0, FP_MAXF_MAG};
                default:   round_res = {sign_q, FP_INF_MAG};
            endcase
        end else begin
            round_res = {sign_q, exp_f[7:0], frac};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Dropping valid while busy abandons the operation without touching reg_out.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (valid) state_nx = is_special ? S_DONE : S_ITER;
            S_ITER:  if (!valid) state_nx = S_IDLE;
                     else if (last_iter) state_nx = S_ROUND;
            S_ROUND: state_nx = valid ? S_DONE : S_IDLE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign halt = (valid && !rst && state != S_DONE) ? 4'b0001 : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_out <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            case (state)
                S_IDLE: if (valid) begin
                    sign_q <= s_new;
                    exp_q  <= {2'b00, ea} - {2'b00, eb} + 10'(FP_BIAS);
                    rem_q  <= {1'b0, ma};
                    div_q  <= mb;
                    q_q    <= '0;
                    cnt_q  <= '0;
                    if (is_special) reg_out <= special_res;
                end
                S_ITER: if (valid) begin
                    rem_q <= {rem_sub[23:0], 1'b0};
                    q_q   <= {q_q[25:0], rem_ge};
                    if (!last_iter) cnt_q <= cnt_q + 5'd1;
                end
                S_ROUND: if (valid) reg_out <= round_res;
                default: ;
            endcase
        end
    end
endmodule
